// File: rtl/fixed_point_pkg.sv
// Shared fixed-point and sequencer definitions for the MLP layer datapath control.
// Q4.4 data width, activation encodings and the sequencer state encoding.
package fixed_point_pkg;

    localparam int Q44_W = 8;

    typedef enum logic [1:0] {
        ACT_RELU = 2'b00,
        ACT_PASS = 2'b11
    } act_type_e;

    typedef logic [3:0] seq_state_e;

    localparam seq_state_e S_IDLE     = 4'd0;
    localparam seq_state_e S_CLEAR    = 4'd1;
    localparam seq_state_e S_LOAD     = 4'd2;
    localparam seq_state_e S_MAC      = 4'd3;
    localparam seq_state_e S_WAIT_MAC = 4'd4;
    localparam seq_state_e S_SETTLE   = 4'd5;
    localparam seq_state_e S_ACT      = 4'd6;
    localparam seq_state_e S_WAIT_ACT = 4'd7;
    localparam seq_state_e S_WRITE    = 4'd8;
    localparam seq_state_e S_DONE     = 4'd9;

    // Address widths never collapse to zero bits, even for a single entry.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mlp_neuron_sequencer.sv
// Per-neuron control sequencer for one fully-connected layer on mlp_compute_datapath.
// Optional cycle counter output perf_cycles when MLP_SEQ_PERF_EN is defined.
//
// state    | meaning
// IDLE     | waiting for start
// CLEAR    | pulse mac_clear, present (neuron, chunk 0) addresses
// LOAD     | register input/weight chunk and bias into datapath operands
// MAC      | pulse mac_enable
// WAIT_MAC | hold operands until mac_valid; advance chunk or go settle
// SETTLE   | two cycles for the accumulator to settle
// ACT      | pulse activation_enable
// WAIT_ACT | wait for result_valid, capture result
// WRITE    | write result to output buffer, advance neuron
// DONE     | one-cycle done pulse
module mlp_neuron_sequencer
    import fixed_point_pkg::*;
#(
    parameter int  LANES     = 8,
    parameter int  IN_DIM    = 32,
    parameter int  N_NEURONS = 16,
    localparam int CHUNKS    = IN_DIM / LANES,
    localparam int IA_W      = clog2_min1(CHUNKS),
    localparam int WA_W      = clog2_min1(N_NEURONS * CHUNKS),
    localparam int NA_W      = clog2_min1(N_NEURONS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               act_type,
    output logic                     busy,
    output logic                     done,
    output logic [IA_W-1:0]          in_rd_addr,
    input  logic [LANES*8-1:0]       in_rd_data,
    output logic [WA_W-1:0]          wt_rd_addr,
    input  logic [LANES*8-1:0]       wt_rd_data,
    output logic [NA_W-1:0]          bias_rd_addr,
    input  logic [7:0]               bias_rd_data,
    output logic                     dp_mac_clear,
    output logic                     dp_mac_enable,
    output logic                     dp_act_enable,
    output logic [1:0]               dp_act_type,
    output logic [LANES-1:0][7:0]    dp_data,
    output logic [LANES-1:0][7:0]    dp_weight,
    output logic [7:0]               dp_bias,
    input  logic                     dp_mac_valid,
    input  logic [Q44_W-1:0]         dp_result,
    input  logic                     dp_result_valid,
    output logic                     out_wr_en,
    output logic [NA_W-1:0]          out_wr_addr,
    output logic [Q44_W-1:0]         out_wr_data
`ifdef MLP_SEQ_PERF_EN
    ,
    output logic [31:0]              perf_cycles
`endif
);

    localparam logic [IA_W-1:0] CHUNK_LAST  = IA_W'(CHUNKS - 1);
    localparam logic [NA_W-1:0] NEURON_LAST = NA_W'(N_NEURONS - 1);
    localparam logic [WA_W-1:0] CHUNKS_W    = WA_W'(CHUNKS);
    localparam logic [1:0]      SETTLE_LOAD = 2'd1;

    seq_state_e             state;
    logic [IA_W-1:0]        chunk;
    logic [NA_W-1:0]        neuron;
    logic [1:0]             settle;
    logic [1:0]             act_type_q;
    logic [Q44_W-1:0]       result_q;
    logic                   last_chunk;
    logic                   mac_step;

    assign last_chunk = (chunk == CHUNK_LAST);
    assign mac_step   = (state == S_WAIT_MAC) && dp_mac_valid && !last_chunk;

    // The next chunk address is presented on the mac_valid cycle so the
    // sync-read memories have its data ready when LOAD samples them.
    assign in_rd_addr   = mac_step ? (chunk + IA_W'(1)) : chunk;
    assign wt_rd_addr   = WA_W'(neuron) * CHUNKS_W + WA_W'(in_rd_addr);
    assign bias_rd_addr = neuron;

    assign dp_mac_clear  = (state == S_CLEAR);
    assign dp_mac_enable = (state == S_MAC);
    assign dp_act_enable = (state == S_ACT);
    assign out_wr_en     = (state == S_WRITE);
    assign done          = (state == S_DONE);
    assign busy          = (state != S_IDLE) && (state != S_DONE);
    assign dp_act_type   = act_type_q;
    assign out_wr_addr   = neuron;
    assign out_wr_data   = result_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            chunk      <= '0;
            neuron     <= '0;
            settle     <= '0;
            act_type_q <= ACT_RELU;
            dp_data    <= '0;
            dp_weight  <= '0;
            dp_bias    <= '0;
            result_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        act_type_q <= act_type;
                        neuron     <= '0;
                        chunk      <= '0;
                        state      <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    chunk <= '0;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    dp_data   <= in_rd_data;
                    dp_weight <= wt_rd_data;
                    dp_bias   <= bias_rd_data;
                    state     <= S_MAC;
                end
                S_MAC: begin
                    state <= S_WAIT_MAC;
                end
                S_WAIT_MAC: begin
                    if (dp_mac_valid) begin
                        if (!last_chunk) begin
                            chunk <= chunk + IA_W'(1);
                            state <= S_LOAD;
                        end else begin
                            chunk  <= '0;
                            settle <= SETTLE_LOAD;
                            state  <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle == 2'd0) begin
                        state <= S_ACT;
                    end else begin
                        settle <= settle - 2'd1;
                    end
                end
                S_ACT: begin
                    state <= S_WAIT_ACT;
                end
                S_WAIT_ACT: begin
                    if (dp_result_valid) begin
                        result_q <= dp_result;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (neuron == NEURON_LAST) begin
                        neuron <= '0;
                        state  <= S_DONE;
                    end else begin
                        neuron <= neuron + NA_W'(1);
                        state  <= S_CLEAR;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MLP_SEQ_PERF_EN
    // Start cycle counts as 1; every non-idle cycle through DONE adds one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if ((state == S_IDLE) && start) begin
            perf_cycles <= 32'd1;
        end else if ((state != S_IDLE) && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mlp_neuron_sequencer.sv
// Directed bench: two sequencer instances, each with a behavioural datapath and sync-read memories.
// Instance a: IN_DIM=8, 1 neuron.  Instance b: IN_DIM=16, 3 neurons.
module tb_mlp_neuron_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- instance a signals ----------------
    logic            a_rst_n, a_start, a_busy, a_done;
    logic [1:0]      a_act_type, a_dp_act_type;
    logic [0:0]      a_in_rd_addr, a_wt_rd_addr, a_bias_rd_addr, a_wr_addr;
    logic [63:0]     a_in_rd_data, a_wt_rd_data;
    logic [7:0]      a_bias_rd_data, a_dp_bias, a_result, a_wr_data;
    logic            a_mac_clear, a_mac_enable, a_act_enable, a_mac_valid, a_result_valid, a_wr_en;
    logic [7:0][7:0] a_dp_data, a_dp_weight;
    logic [63:0]     a_in_mem [0:1];
    logic [63:0]     a_wt_mem [0:1];
    logic [7:0]      a_bias_mem [0:1];
`ifdef MLP_SEQ_PERF_EN
    logic [31:0]     a_perf, b_perf;
`endif

    // ---------------- instance b signals ----------------
    logic            b_rst_n, b_start, b_busy, b_done;
    logic [1:0]      b_act_type, b_dp_act_type;
    logic [0:0]      b_in_rd_addr;
    logic [2:0]      b_wt_rd_addr;
    logic [1:0]      b_bias_rd_addr, b_wr_addr;
    logic [63:0]     b_in_rd_data, b_wt_rd_data;
    logic [7:0]      b_bias_rd_data, b_dp_bias, b_result, b_wr_data;
    logic            b_mac_clear, b_mac_enable, b_act_enable, b_mac_valid, b_result_valid, b_wr_en;
    logic [7:0][7:0] b_dp_data, b_dp_weight;
    logic [63:0]     b_in_mem [0:1];
    logic [63:0]     b_wt_mem [0:7];
    logic [7:0]      b_bias_mem [0:3];

    mlp_neuron_sequencer #(.LANES(8), .IN_DIM(8), .N_NEURONS(1)) u_a (
        .clk(clk), .rst_n(a_rst_n), .start(a_start), .act_type(a_act_type),
        .busy(a_busy), .done(a_done),
        .in_rd_addr(a_in_rd_addr), .in_rd_data(a_in_rd_data),
        .wt_rd_addr(a_wt_rd_addr), .wt_rd_data(a_wt_rd_data),
        .bias_rd_addr(a_bias_rd_addr), .bias_rd_data(a_bias_rd_data),
        .dp_mac_clear(a_mac_clear), .dp_mac_enable(a_mac_enable), .dp_act_enable(a_act_enable),
        .dp_act_type(a_dp_act_type), .dp_data(a_dp_data), .dp_weight(a_dp_weight), .dp_bias(a_dp_bias),
        .dp_mac_valid(a_mac_valid), .dp_result(a_result), .dp_result_valid(a_result_valid),
        .out_wr_en(a_wr_en), .out_wr_addr(a_wr_addr), .out_wr_data(a_wr_data)
`ifdef MLP_SEQ_PERF_EN
        , .perf_cycles(a_perf)
`endif
    );

    mlp_neuron_sequencer #(.LANES(8), .IN_DIM(16), .N_NEURONS(3)) u_b (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .act_type(b_act_type),
        .busy(b_busy), .done(b_done),
        .in_rd_addr(b_in_rd_addr), .in_rd_data(b_in_rd_data),
        .wt_rd_addr(b_wt_rd_addr), .wt_rd_data(b_wt_rd_data),
        .bias_rd_addr(b_bias_rd_addr), .bias_rd_data(b_bias_rd_data),
        .dp_mac_clear(b_mac_clear), .dp_mac_enable(b_mac_enable), .dp_act_enable(b_act_enable),
        .dp_act_type(b_dp_act_type), .dp_data(b_dp_data), .dp_weight(b_dp_weight), .dp_bias(b_dp_bias),
        .dp_mac_valid(b_mac_valid), .dp_result(b_result), .dp_result_valid(b_result_valid),
        .out_wr_en(b_wr_en), .out_wr_addr(b_wr_addr), .out_wr_data(b_wr_data)
`ifdef MLP_SEQ_PERF_EN
        , .perf_cycles(b_perf)
`endif
    );

    // ---------------- behavioural datapath ----------------
    function automatic logic signed [19:0] dot8(input logic [7:0][7:0] d, input logic [7:0][7:0] w);
        logic signed [19:0] s;
        logic signed [7:0]  x, y;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            x = d[i];
            y = w[i];
            s = s + x * y;
        end
        return s;
    endfunction

    // Q8.8 accumulator plus Q4.4 bias, rescaled to Q4.4; ReLU clamps to 0..255.
    function automatic logic [7:0] activate(input logic signed [19:0] acc, input logic [7:0] bias,
                                            input logic [1:0] t);
        logic signed [7:0]  b;
        logic signed [19:0] bx, v;
        logic [7:0]         r;
        b  = bias;
        bx = b;
        v  = (acc + bx * 16) >>> 4;
        if (t == 2'b00) begin
            if (v < 0)        r = 8'h00;
            else if (v > 255) r = 8'hFF;
            else              r = v[7:0];
        end else begin
            if (v < -128)     r = 8'h80;
            else if (v > 127) r = 8'h7F;
            else              r = v[7:0];
        end
        return r;
    endfunction

    logic signed [19:0] a_acc, b_acc;
    logic [2:0]         a_act_sr, b_act_sr;
    assign a_result_valid = a_act_sr[2];
    assign b_result_valid = b_act_sr[2];

    always @(posedge clk) begin
        if (!a_rst_n) begin
            a_acc <= '0; a_mac_valid <= 1'b0; a_act_sr <= '0; a_result <= '0;
        end else begin
            a_mac_valid <= a_mac_enable;
            a_act_sr    <= {a_act_sr[1:0], a_act_enable};
            if (a_mac_clear)       a_acc <= '0;
            else if (a_mac_enable) a_acc <= a_acc + dot8(a_dp_data, a_dp_weight);
            if (a_act_enable)      a_result <= activate(a_acc, a_dp_bias, a_dp_act_type);
        end
        a_in_rd_data   <= a_in_mem[a_in_rd_addr];
        a_wt_rd_data   <= a_wt_mem[a_wt_rd_addr];
        a_bias_rd_data <= a_bias_mem[a_bias_rd_addr];
    end

    always @(posedge clk) begin
        if (!b_rst_n) begin
            b_acc <= '0; b_mac_valid <= 1'b0; b_act_sr <= '0; b_result <= '0;
        end else begin
            b_mac_valid <= b_mac_enable;
            b_act_sr    <= {b_act_sr[1:0], b_act_enable};
            if (b_mac_clear)       b_acc <= '0;
            else if (b_mac_enable) b_acc <= b_acc + dot8(b_dp_data, b_dp_weight);
            if (b_act_enable)      b_result <= activate(b_acc, b_dp_bias, b_dp_act_type);
        end
        b_in_rd_data   <= b_in_mem[b_in_rd_addr];
        b_wt_rd_data   <= b_wt_mem[b_wt_rd_addr];
        b_bias_rd_data <= b_bias_mem[b_bias_rd_addr];
    end

    // ---------------- event monitors ----------------
    int a_n_clear = 0, a_n_en = 0, a_n_act = 0, a_n_wr = 0, a_n_done = 0, a_n_ovl = 0, a_n_aerr = 0;
    int b_n_clear = 0, b_n_en = 0, b_n_act = 0, b_n_wr = 0, b_n_done = 0, b_n_ovl = 0, b_n_aerr = 0;
    int b_ens = 0, b_n_seq = 0;
    logic [7:0] a_wr_data_log [0:31];
    logic [0:0] a_wr_addr_log [0:31];
    logic [7:0] b_wr_data_log [0:31];
    logic [1:0] b_wr_addr_log [0:31];

    always @(negedge clk) begin
        if (a_mac_clear)  a_n_clear++;
        if (a_mac_enable) a_n_en++;
        if (a_act_enable) a_n_act++;
        if (a_done)       a_n_done++;
        if (a_wr_en) begin
            a_wr_data_log[a_n_wr % 32] = a_wr_data;
            a_wr_addr_log[a_n_wr % 32] = a_wr_addr;
            a_n_wr++;
        end
        if (int'(a_mac_clear) + int'(a_mac_enable) + int'(a_act_enable) + int'(a_wr_en) + int'(a_done) > 1)
            a_n_ovl++;
        if (a_in_rd_addr != 1'b0 || a_wt_rd_addr != 1'b0 || a_bias_rd_addr != 1'b0) a_n_aerr++;

        if (b_mac_clear) begin b_n_clear++; b_ens = 0; end
        if (b_mac_enable) begin b_n_en++; b_ens++; end
        if (b_act_enable) begin b_n_act++; if (b_ens != 2) b_n_seq++; end
        if (b_done)       b_n_done++;
        if (b_wr_en) begin
            b_wr_data_log[b_n_wr % 32] = b_wr_data;
            b_wr_addr_log[b_n_wr % 32] = b_wr_addr;
            b_n_wr++;
        end
        if (int'(b_mac_clear) + int'(b_mac_enable) + int'(b_act_enable) + int'(b_wr_en) + int'(b_done) > 1)
            b_n_ovl++;
        if (b_in_rd_addr > 1'd1 || b_wt_rd_addr > 3'd5 || b_bias_rd_addr > 2'd2) b_n_aerr++;
    end

    // ---------------- run helpers (stimulus only) ----------------
    task automatic run_a(input logic [1:0] at, output int span, output bit to, output bit busy_first);
        @(negedge clk);
        a_act_type = at;
        a_start    = 1'b1;
        span = 1; to = 1'b1; busy_first = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a_start = 1'b0;
            span++;
            if (span == 2) busy_first = a_busy;
            if (a_done) begin to = 1'b0; break; end
        end
    endtask

    task automatic run_b(input logic [1:0] at, output bit to);
        @(negedge clk);
        b_act_type = at;
        b_start    = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (b_done) begin to = 1'b0; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({a_busy, a_done, a_mac_clear, a_mac_enable, a_act_enable, a_dp_act_type, a_in_rd_addr,
             a_wt_rd_addr, a_bias_rd_addr, a_dp_data, a_dp_weight, a_dp_bias, a_wr_en, a_wr_addr,
             a_wr_data} !== '0) begin
            miscompares++; $display("FAIL reset_a_outputs: some output nonzero, expected all 0");
        end
        vectors++;
        if ({b_busy, b_done, b_mac_clear, b_mac_enable, b_act_enable, b_dp_act_type, b_in_rd_addr,
             b_wt_rd_addr, b_bias_rd_addr, b_dp_data, b_dp_weight, b_dp_bias, b_wr_en, b_wr_addr,
             b_wr_data} !== '0) begin
            miscompares++; $display("FAIL reset_b_outputs: some output nonzero, expected all 0");
        end
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({a_busy, a_done, b_busy, b_done} !== 4'b0000) begin
            miscompares++; $display("FAIL idle_after_reset: busy/done=%b expected 0000", {a_busy, a_done, b_busy, b_done});
        end
    endtask

    task automatic test_single_chunk();
        int span, wr0, cl0, en0, ac0, dn0, ov0;
        bit to, bf;
        a_in_mem[0] = {8{8'h10}}; a_wt_mem[0] = {8{8'h10}}; a_bias_mem[0] = 8'h00;
        wr0 = a_n_wr; cl0 = a_n_clear; en0 = a_n_en; ac0 = a_n_act; dn0 = a_n_done; ov0 = a_n_ovl;
        run_a(2'b00, span, to, bf);
        vectors++;
        if (to) begin miscompares++; $display("FAIL single_timeout: no done within bound"); end
        vectors++;
        if (bf !== 1'b1) begin miscompares++; $display("FAIL single_busy: busy=%b after start, expected 1", bf); end
        @(negedge clk);
        #1;
        vectors++;
        if (a_done !== 1'b0) begin miscompares++; $display("FAIL single_done_width: done=%b on 2nd cycle, expected 0", a_done); end
        vectors++;
        if (a_n_wr - wr0 != 1) begin miscompares++; $display("FAIL single_writes: %0d expected 1", a_n_wr - wr0); end
        vectors++;
        if (a_wr_addr_log[wr0 % 32] !== 1'b0 || a_wr_data_log[wr0 % 32] !== 8'h80) begin
            miscompares++; $display("FAIL single_write: addr=%0d data=%h expected addr=0 data=80",
                                    a_wr_addr_log[wr0 % 32], a_wr_data_log[wr0 % 32]);
        end
        vectors++;
        if (a_n_clear - cl0 != 1 || a_n_en - en0 != 1 || a_n_act - ac0 != 1 || a_n_done - dn0 != 1) begin
            miscompares++; $display("FAIL single_pulses: clear=%0d en=%0d act=%0d done=%0d expected 1 1 1 1",
                                    a_n_clear - cl0, a_n_en - en0, a_n_act - ac0, a_n_done - dn0);
        end
        vectors++;
        if (a_n_ovl != ov0) begin miscompares++; $display("FAIL single_overlap: %0d overlapping pulses, expected 0", a_n_ovl - ov0); end
        vectors++;
        if (span != 13) begin miscompares++; $display("FAIL single_latency: span=%0d cycles expected 13", span); end
    endtask

    task automatic test_reset_mid_op();
        int wr0, dn0, span;
        bit found, to, bf;
        @(negedge clk);
        a_act_type = 2'b11;
        a_start    = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (a_act_enable) begin found = 1'b1; break; end
            @(negedge clk);
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL midrst_act_timeout: no act pulse within bound"); end
        @(negedge clk);
        vectors++;
        if (a_dp_act_type !== 2'b11) begin miscompares++; $display("FAIL midrst_act_type: %b expected 11", a_dp_act_type); end
        wr0 = a_n_wr; dn0 = a_n_done;
        a_rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({a_busy, a_done, a_mac_clear, a_mac_enable, a_act_enable, a_dp_act_type, a_in_rd_addr,
             a_wt_rd_addr, a_bias_rd_addr, a_dp_data, a_dp_weight, a_dp_bias, a_wr_en, a_wr_addr,
             a_wr_data} !== '0) begin
            miscompares++; $display("FAIL midrst_outputs: wr_data=%h act_type=%b busy=%b expected all 0",
                                    a_wr_data, a_dp_act_type, a_busy);
        end
        a_rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        vectors++;
        if (a_n_wr != wr0 || a_n_done != dn0) begin
            miscompares++; $display("FAIL midrst_abort: writes=%0d dones=%0d expected 0 0", a_n_wr - wr0, a_n_done - dn0);
        end
        run_a(2'b00, span, to, bf);
        @(negedge clk);
        #1;
        vectors++;
        if (to || a_n_wr - wr0 != 1 || a_wr_data_log[wr0 % 32] !== 8'h80) begin
            miscompares++; $display("FAIL midrst_rerun: timeout=%b writes=%0d data=%h expected 0 1 80",
                                    to, a_n_wr - wr0, a_wr_data_log[wr0 % 32]);
        end
    endtask

    task automatic test_saturate();
        int wr0, en0, cl0, sq0;
        bit to;
        b_in_mem[0] = {8{8'h10}}; b_in_mem[1] = {8{8'h10}};
        for (int i = 0; i < 8; i++) b_wt_mem[i] = {8{8'h10}};
        for (int i = 0; i < 4; i++) b_bias_mem[i] = 8'h00;
        wr0 = b_n_wr; en0 = b_n_en; cl0 = b_n_clear; sq0 = b_n_seq;
        run_b(2'b00, to);
        @(negedge clk);
        #1;
        vectors++;
        if (to) begin miscompares++; $display("FAIL sat_timeout: no done within bound"); end
        vectors++;
        if (b_n_en - en0 != 6 || b_n_clear - cl0 != 3) begin
            miscompares++; $display("FAIL sat_pulses: enables=%0d clears=%0d expected 6 3", b_n_en - en0, b_n_clear - cl0);
        end
        vectors++;
        if (b_n_seq != sq0) begin miscompares++; $display("FAIL sat_grouping: %0d neurons without 2 enables after clear, expected 0", b_n_seq - sq0); end
        vectors++;
        if (b_n_wr - wr0 != 3) begin miscompares++; $display("FAIL sat_writes: %0d expected 3", b_n_wr - wr0); end
        for (int n = 0; n < 3; n++) begin
            vectors++;
            if (b_wr_data_log[(wr0 + n) % 32] !== 8'hFF) begin
                miscompares++; $display("FAIL sat_data%0d: %h expected ff", n, b_wr_data_log[(wr0 + n) % 32]);
            end
        end
    endtask

    task automatic test_layer();
        int wr0, ov0, ae0;
        bit to;
        logic [7:0] exp_d [0:2];
        logic [7:0] w_n   [0:2];
        exp_d[0] = 8'h90; exp_d[1] = 8'h00; exp_d[2] = 8'h90;
        w_n[0]   = 8'h10; w_n[1]   = 8'hF0; w_n[2]   = 8'h10;
        b_in_mem[0] = {8{8'h10}}; b_in_mem[1] = '0;
        for (int n = 0; n < 3; n++) begin
            b_wt_mem[n * 2]     = {8{w_n[n]}};
            b_wt_mem[n * 2 + 1] = {8{w_n[n]}};
            b_bias_mem[n]       = 8'h10;
        end
        wr0 = b_n_wr; ov0 = b_n_ovl; ae0 = b_n_aerr;
        run_b(2'b00, to);
        @(negedge clk);
        #1;
        vectors++;
        if (to || b_n_wr - wr0 != 3) begin
            miscompares++; $display("FAIL layer_writes: timeout=%b writes=%0d expected 0 3", to, b_n_wr - wr0);
        end
        for (int n = 0; n < 3; n++) begin
            vectors++;
            if (b_wr_addr_log[(wr0 + n) % 32] !== 2'(n) || b_wr_data_log[(wr0 + n) % 32] !== exp_d[n]) begin
                miscompares++; $display("FAIL layer_write%0d: addr=%0d data=%h expected addr=%0d data=%h", n,
                                        b_wr_addr_log[(wr0 + n) % 32], b_wr_data_log[(wr0 + n) % 32], n, exp_d[n]);
            end
        end
        vectors++;
        if (b_n_ovl != ov0 || b_n_aerr != ae0) begin
            miscompares++; $display("FAIL layer_hygiene: overlaps=%0d addr_range_errs=%0d expected 0 0",
                                    b_n_ovl - ov0, b_n_aerr - ae0);
        end
    endtask

    task automatic test_start_ignored();
        int wr0, dn0;
        bit found, to;
        wr0 = b_n_wr; dn0 = b_n_done;
        @(negedge clk);
        b_act_type = 2'b00;
        b_start    = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (b_mac_enable) begin found = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (b_done) begin to = 1'b0; break; end
            @(negedge clk);
        end
        repeat (60) @(negedge clk);
        #1;
        vectors++;
        if (!found || to) begin miscompares++; $display("FAIL ignore_timeout: mac_seen=%b done_timeout=%b expected 1 0", found, to); end
        vectors++;
        if (b_n_wr - wr0 != 3 || b_n_done - dn0 != 1) begin
            miscompares++; $display("FAIL ignore_start: writes=%0d dones=%0d expected 3 1", b_n_wr - wr0, b_n_done - dn0);
        end
    endtask

`ifdef MLP_SEQ_PERF_EN
    task automatic test_perf();
        int span;
        bit to, bf;
        run_a(2'b00, span, to, bf);
        @(negedge clk);
        vectors++;
        if (to || a_perf !== 32'(span)) begin
            miscompares++; $display("FAIL perf_span: timeout=%b perf=%0d expected %0d", to, a_perf, span);
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (a_perf !== 32'(span)) begin miscompares++; $display("FAIL perf_hold: perf=%0d expected %0d", a_perf, span); end
    endtask
`endif

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_start = 1'b0; b_start = 1'b0;
        a_act_type = 2'b00; b_act_type = 2'b00;
        for (int i = 0; i < 2; i++) begin a_in_mem[i] = '0; a_wt_mem[i] = '0; a_bias_mem[i] = '0; b_in_mem[i] = '0; end
        for (int i = 0; i < 8; i++) b_wt_mem[i] = '0;
        for (int i = 0; i < 4; i++) b_bias_mem[i] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single_chunk();
        test_reset_mid_op();
        test_saturate();
        test_layer();
        test_start_ignored();
`ifdef MLP_SEQ_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
